// File: rtl/pixel_filter_stream.sv
// pixel_filter_stream: three-stage point-wise RGB filter on a valid/ready
// stream. Filter configuration is latched on each accepted start-of-frame
// beat, so every pixel of a frame is processed with the same settings.
module pixel_filter_stream #(
    parameter int DATA_W    = 8,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 4,
    parameter int FCNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [2:0]        cfg_mode,
    input  logic [GAIN_W-1:0] cfg_gain,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [2:0]        cfg_levels,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    output logic              out_sof,
    output logic              out_eol,
    output logic [FCNT_W-1:0] frame_count,
    output logic [2:0]        active_mode
);

    localparam int PW = DATA_W + 8;          // coefficient product width
    localparam int SW = DATA_W + 10;         // weighted-sum width
    localparam int GW = DATA_W + GAIN_W;     // unsigned gain product width
    localparam int CW = DATA_W + GAIN_W + 2; // signed working width

    localparam logic [DATA_W-1:0]        MAX_C    = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0]        MID_C    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [CW-1:0]     ZERO_W   = {CW{1'b0}};
    localparam logic signed [CW-1:0]     MAX_W    = $signed({{(CW-DATA_W){1'b0}}, MAX_C});
    localparam logic signed [CW-1:0]     MID_W    = $signed({{(CW-DATA_W){1'b0}}, MID_C});
    localparam logic [GAIN_W-1:0]        GAIN_ONE = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;
    localparam logic [3:0]               LEV_DEF  = 4'(DATA_W);
    localparam logic [FCNT_W-1:0]        FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    // Coefficients: 0..2 luma, 3..5 sepia red, 6..8 sepia green, 9..11 sepia blue.
    // Entry i always multiplies channel i % 3.
    function automatic logic [7:0] coef(input logic [3:0] idx);
        logic [7:0] c;
        case (idx)
            4'd0:    c = 8'd77;
            4'd1:    c = 8'd150;
            4'd2:    c = 8'd29;
            4'd3:    c = 8'd100;
            4'd4:    c = 8'd196;
            4'd5:    c = 8'd48;
            4'd6:    c = 8'd89;
            4'd7:    c = 8'd175;
            4'd8:    c = 8'd43;
            4'd9:    c = 8'd70;
            4'd10:   c = 8'd136;
            4'd11:   c = 8'd33;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    // Posterize level: 0 behaves as 1, anything wider than a channel keeps all bits.
    function automatic logic [3:0] lev_clamp(input logic [2:0] lv);
        logic [3:0] r;
        if (lv == 3'd0) r = 4'd1;
        else if ({1'b0, lv} > LEV_DEF) r = LEV_DEF;
        else r = {1'b0, lv};
        return r;
    endfunction

    // Mask keeping the top lv bits of a channel.
    function automatic logic [DATA_W-1:0] post_mask(input logic [3:0] lv);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i >= (DATA_W - int'(lv)));
        end
        return m;
    endfunction

    // Saturate a signed working value into [0, MAX].
    function automatic logic [DATA_W-1:0] clamp_px(input logic signed [CW-1:0] v);
        logic [DATA_W-1:0] r;
        if (v < ZERO_W) r = {DATA_W{1'b0}};
        else if (v > MAX_W) r = MAX_C;
        else r = v[DATA_W-1:0];
        return r;
    endfunction

    logic                     en_s;
    logic [2:0]               shd_mode_r;
    logic [GAIN_W-1:0]        shd_gain_r;
    logic [DATA_W-1:0]        shd_thresh_r;
    logic [3:0]               shd_lev_r;
    logic [2:0]               eff_mode_s;
    logic [GAIN_W-1:0]        eff_gain_s;
    logic [DATA_W-1:0]        eff_thresh_s;
    logic [3:0]               eff_lev_s;
    logic [DATA_W-1:0]        pix_s    [0:2];
    logic [PW-1:0]            cprod_s  [0:11];
    logic [GW-1:0]            gprod_s  [0:2];
    logic signed [CW-1:0]     diff_s   [0:2];
    logic signed [CW-1:0]     dprod_s  [0:2];

    logic                     v1_r, sof1_r, eol1_r;
    logic [DATA_W-1:0]        pix1_r   [0:2];
    logic [2:0]               mode1_r;
    logic [DATA_W-1:0]        thresh1_r;
    logic [3:0]               lev1_r;
    logic [PW-1:0]            cprod1_r [0:11];
    logic [GW-1:0]            gprod1_r [0:2];
    logic signed [CW-1:0]     dprod1_r [0:2];

    logic [SW-1:0]            gray_s;
    logic [SW-1:0]            sep_s    [0:2];
    logic [DATA_W-1:0]        mask_s;
    logic                     thr_hit_s;
    logic signed [CW-1:0]     pre_s    [0:2];

    logic                     v2_r, sof2_r, eol2_r;
    logic signed [CW-1:0]     pre2_r   [0:2];

    assign en_s        = !out_valid || out_ready;
    assign in_ready    = en_s;
    assign active_mode = shd_mode_r;
    assign pix_s[0]    = in_r;
    assign pix_s[1]    = in_g;
    assign pix_s[2]    = in_b;

    // Config seen by the incoming beat: a sof beat uses the live inputs it loads.
    always_comb begin
        if (in_sof) begin
            eff_mode_s   = cfg_mode;
            eff_gain_s   = cfg_gain;
            eff_thresh_s = cfg_thresh;
            eff_lev_s    = lev_clamp(cfg_levels);
        end else begin
            eff_mode_s   = shd_mode_r;
            eff_gain_s   = shd_gain_r;
            eff_thresh_s = shd_thresh_r;
            eff_lev_s    = shd_lev_r;
        end
    end

    // Stage-1 multipliers: luma/sepia weights, gain and contrast products.
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            cprod_s[i] = PW'(coef(4'(i))) * PW'(pix_s[i % 3]);
        end
        for (int c = 0; c < 3; c++) begin
            gprod_s[c] = GW'(pix_s[c]) * GW'(eff_gain_s);
            diff_s[c]  = $signed(CW'(pix_s[c])) - MID_W;
            dprod_s[c] = diff_s[c] * $signed(CW'(eff_gain_s));
        end
    end

    // Frame config shadow and frame counter, loaded on every accepted sof.
    always_ff @(posedge clk) begin
        if (reset) begin
            shd_mode_r   <= 3'd0;
            shd_gain_r   <= GAIN_ONE;
            shd_thresh_r <= MID_C;
            shd_lev_r    <= LEV_DEF;
            frame_count  <= {FCNT_W{1'b0}};
        end else if (in_valid && en_s && in_sof) begin
            shd_mode_r   <= cfg_mode;
            shd_gain_r   <= cfg_gain;
            shd_thresh_r <= cfg_thresh;
            shd_lev_r    <= lev_clamp(cfg_levels);
            frame_count  <= frame_count + FCNT_ONE;
        end
    end

    // Stage 1: capture pixel, sidebands, per-beat config and products.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r      <= 1'b0;
            sof1_r    <= 1'b0;
            eol1_r    <= 1'b0;
            mode1_r   <= 3'd0;
            thresh1_r <= {DATA_W{1'b0}};
            lev1_r    <= 4'd0;
            for (int i = 0; i < 12; i++) cprod1_r[i] <= {PW{1'b0}};
            for (int c = 0; c < 3; c++) begin
                pix1_r[c]   <= {DATA_W{1'b0}};
                gprod1_r[c] <= {GW{1'b0}};
                dprod1_r[c] <= ZERO_W;
            end
        end else if (en_s) begin
            v1_r      <= in_valid;
            sof1_r    <= in_valid && in_sof;
            eol1_r    <= in_valid && in_eol;
            mode1_r   <= eff_mode_s;
            thresh1_r <= eff_thresh_s;
            lev1_r    <= eff_lev_s;
            for (int i = 0; i < 12; i++) cprod1_r[i] <= cprod_s[i];
            for (int c = 0; c < 3; c++) begin
                pix1_r[c]   <= pix_s[c];
                gprod1_r[c] <= gprod_s[c];
                dprod1_r[c] <= dprod_s[c];
            end
        end
    end

    // Stage-2 sums and per-mode pre-clamp selection.
    always_comb begin
        gray_s    = (SW'(cprod1_r[0]) + SW'(cprod1_r[1]) + SW'(cprod1_r[2])) >> 4'd8;
        mask_s    = post_mask(lev1_r);
        thr_hit_s = (gray_s >= SW'(thresh1_r));
        for (int c = 0; c < 3; c++) begin
            sep_s[c] = (SW'(cprod1_r[3 + 3*c]) + SW'(cprod1_r[4 + 3*c])
                        + SW'(cprod1_r[5 + 3*c])) >> 4'd8;
            case (mode1_r)
                3'd0:    pre_s[c] = $signed(CW'(pix1_r[c]));
                3'd1:    pre_s[c] = $signed(CW'(gray_s));
                3'd2:    pre_s[c] = $signed(CW'(MAX_C - pix1_r[c]));
                3'd3:    pre_s[c] = $signed(CW'(sep_s[c]));
                3'd4:    pre_s[c] = $signed(CW'(gprod1_r[c] >> GAIN_FRAC));
                3'd5:    pre_s[c] = (dprod1_r[c] >>> GAIN_FRAC) + MID_W;
                3'd6:    pre_s[c] = thr_hit_s ? MAX_W : ZERO_W;
                3'd7:    pre_s[c] = $signed(CW'(pix1_r[c] & mask_s));
                default: pre_s[c] = ZERO_W;
            endcase
        end
    end

    // Stage 2: hold the unclamped result with its sidebands.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r   <= 1'b0;
            sof2_r <= 1'b0;
            eol2_r <= 1'b0;
            for (int c = 0; c < 3; c++) pre2_r[c] <= ZERO_W;
        end else if (en_s) begin
            v2_r   <= v1_r;
            sof2_r <= sof1_r;
            eol2_r <= eol1_r;
            for (int c = 0; c < 3; c++) pre2_r[c] <= pre_s[c];
        end
    end

    // Stage 3: saturate and drive the registered output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_r     <= {DATA_W{1'b0}};
            out_g     <= {DATA_W{1'b0}};
            out_b     <= {DATA_W{1'b0}};
        end else if (en_s) begin
            out_valid <= v2_r;
            out_sof   <= sof2_r;
            out_eol   <= eol2_r;
            out_r     <= clamp_px(pre2_r[0]);
            out_g     <= clamp_px(pre2_r[1]);
            out_b     <= clamp_px(pre2_r[2]);
        end
    end

endmodule

// File: tb/tb_pixel_filter_stream.sv
// Directed and randomised self-checking bench for pixel_filter_stream (DATA_W=8).
module tb_pixel_filter_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_sof, in_eol;
    logic [7:0] in_r, in_g, in_b;
    logic [2:0] cfg_mode, cfg_levels;
    logic [7:0] cfg_gain, cfg_thresh;
    logic       out_valid, out_ready, out_sof, out_eol;
    logic [7:0] out_r, out_g, out_b;
    logic [15:0] frame_count;
    logic [2:0] active_mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] r, g, b;
        logic       sof, eol;
        logic [2:0] mode;
        logic [7:0] gain, thresh;
        logic [2:0] lev;
    } beat_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic       sof, eol;
    } exp_t;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] gain, thresh;
        logic [2:0] lev;
        logic [7:0] r, g, b;
        logic [7:0] er, eg, eb;
    } vec_t;

    // Reference model state.
    int m_mode, m_gain, m_thr, m_lev, m_fc;
    beat_t src_q[$];

    pixel_filter_stream dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_sof(in_sof), .in_eol(in_eol),
        .cfg_mode(cfg_mode), .cfg_gain(cfg_gain),
        .cfg_thresh(cfg_thresh), .cfg_levels(cfg_levels),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_sof(out_sof), .out_eol(out_eol),
        .frame_count(frame_count), .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Independent integer model of one output channel.
    function automatic int filt(input int mode, input int gain, input int thr, input int lev,
                                input int r, input int g, input int b, input int ch);
        int x, gray, v, keep;
        x    = (ch == 0) ? r : ((ch == 1) ? g : b);
        gray = (77*r + 150*g + 29*b) / 256;
        case (mode)
            0: v = x;
            1: v = gray;
            2: v = 255 - x;
            3: v = (ch == 0) ? (100*r + 196*g + 48*b) / 256 :
                   (ch == 1) ? (89*r + 175*g + 43*b) / 256 : (70*r + 136*g + 33*b) / 256;
            4: v = (x * gain) / 16;
            5: begin
                v = (x - 128) * gain;
                v = (v >= 0) ? v / 16 : -((-v + 15) / 16);
                v = v + 128;
            end
            6: v = (gray >= thr) ? 255 : 0;
            7: begin
                keep = (lev == 0) ? 1 : ((lev > 8) ? 8 : lev);
                v = (x / (1 << (8 - keep))) * (1 << (8 - keep));
            end
            default: v = x;
        endcase
        return sat8(v);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_gain = 16; m_thr = 128; m_lev = 8; m_fc = 0;
    endtask

    task automatic model_accept(input beat_t bt, output exp_t e);
        if (bt.sof) begin
            m_mode = bt.mode; m_gain = bt.gain; m_thr = bt.thresh; m_lev = bt.lev;
            m_fc   = (m_fc + 1) % 65536;
        end
        e.r   = 8'(filt(m_mode, m_gain, m_thr, m_lev, bt.r, bt.g, bt.b, 0));
        e.g   = 8'(filt(m_mode, m_gain, m_thr, m_lev, bt.r, bt.g, bt.b, 1));
        e.b   = 8'(filt(m_mode, m_gain, m_thr, m_lev, bt.r, bt.g, bt.b, 2));
        e.sof = bt.sof;
        e.eol = bt.eol;
    endtask

    task automatic drive(input beat_t bt);
        in_valid = 1'b1;
        in_r = bt.r; in_g = bt.g; in_b = bt.b;
        in_sof = bt.sof; in_eol = bt.eol;
        cfg_mode = bt.mode; cfg_gain = bt.gain; cfg_thresh = bt.thresh; cfg_levels = bt.lev;
    endtask

    // Streams src_q through the DUT with random backpressure/bubbles, scoreboarding outputs.
    task automatic run_stream(input int low_pct, input int bub_pct);
        exp_t exp_q[$];
        exp_t e;
        int   idx   = 0;
        int   guard = 0;
        bit   have;
        while ((idx < src_q.size() || exp_q.size() != 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
            out_ready = ($urandom_range(99) >= low_pct);
            have = (idx < src_q.size()) && ($urandom_range(99) >= bub_pct);
            if (have) drive(src_q[idx]);
            else in_valid = 1'b0;
            #1;
            chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_beat", {out_r, out_g, out_b, out_sof, out_eol},
                        {e.r, e.g, e.b, e.sof, e.eol});
                end
            end
            if (in_valid && in_ready) begin
                model_accept(src_q[idx], e);
                exp_q.push_back(e);
                idx++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (guard >= 20000) chk("stream_timeout", guard, 0);
        src_q.delete();
    endtask

    function automatic beat_t mk(input int r, input int g, input int b, input bit sof,
                                 input bit eol, input int mode);
        beat_t bt;
        bt.r = 8'(r); bt.g = 8'(g); bt.b = 8'(b); bt.sof = sof; bt.eol = eol;
        bt.mode = 3'(mode); bt.gain = 8'h10; bt.thresh = 8'd128; bt.lev = 3'd2;
        return bt;
    endfunction

    vec_t vecs[15];

    initial begin
        vec_t  v;
        beat_t bt;
        exp_t  e;
        int    lat;
        int    fc_a;

        vecs[0]  = '{3'd1, 8'h10, 8'd128, 3'd2, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        vecs[1]  = '{3'd1, 8'h10, 8'd128, 3'd2, 8'd255, 8'd0,   8'd0,   8'd76,  8'd76,  8'd76};
        vecs[2]  = '{3'd0, 8'h10, 8'd128, 3'd2, 8'd12,  8'd34,  8'd56,  8'd12,  8'd34,  8'd56};
        vecs[3]  = '{3'd2, 8'h10, 8'd128, 3'd2, 8'd0,   8'd100, 8'd255, 8'd255, 8'd155, 8'd0};
        vecs[4]  = '{3'd3, 8'h10, 8'd128, 3'd2, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd238};
        vecs[5]  = '{3'd3, 8'h10, 8'd128, 3'd2, 8'd100, 8'd50,  8'd0,   8'd77,  8'd68,  8'd53};
        vecs[6]  = '{3'd4, 8'h18, 8'd128, 3'd2, 8'd200, 8'd100, 8'd0,   8'd255, 8'd150, 8'd0};
        vecs[7]  = '{3'd4, 8'h08, 8'd128, 3'd2, 8'd7,   8'd8,   8'd9,   8'd3,   8'd4,   8'd4};
        vecs[8]  = '{3'd5, 8'h18, 8'd128, 3'd2, 8'd20,  8'd160, 8'd128, 8'd0,   8'd176, 8'd128};
        vecs[9]  = '{3'd5, 8'h18, 8'd128, 3'd2, 8'd255, 8'd127, 8'd0,   8'd255, 8'd126, 8'd0};
        vecs[10] = '{3'd6, 8'h10, 8'd128, 3'd2, 8'd127, 8'd127, 8'd127, 8'd0,   8'd0,   8'd0};
        vecs[11] = '{3'd6, 8'h10, 8'd128, 3'd2, 8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
        vecs[12] = '{3'd7, 8'h10, 8'd128, 3'd2, 8'hB7,  8'hFF,  8'h3F,  8'h80,  8'hC0,  8'h00};
        vecs[13] = '{3'd7, 8'h10, 8'd128, 3'd0, 8'hB7,  8'h7F,  8'hFF,  8'h80,  8'h00,  8'h80};
        vecs[14] = '{3'd7, 8'h10, 8'd128, 3'd7, 8'hB7,  8'h01,  8'hFF,  8'hB6,  8'h00,  8'hFE};

        // Reset state.
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0; in_sof = 1'b0; in_eol = 1'b0;
        cfg_mode = 3'd0; cfg_gain = 8'd0; cfg_thresh = 8'd0; cfg_levels = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pix", {out_r, out_g, out_b, out_sof, out_eol}, 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_active_mode", int'(active_mode), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Directed single-beat vectors: latency and hand-computed results.
        for (int i = 0; i < 15; i++) begin
            v = vecs[i];
            @(negedge clk);
            bt.r = v.r; bt.g = v.g; bt.b = v.b; bt.sof = 1'b1; bt.eol = 1'b1;
            bt.mode = v.mode; bt.gain = v.gain; bt.thresh = v.thresh; bt.lev = v.lev;
            drive(bt);
            out_ready = 1'b1;
            model_accept(bt, e);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_pix", i), {out_r, out_g, out_b}, {v.er, v.eg, v.eb});
            chk($sformatf("vec%0d_side", i), {out_sof, out_eol}, 3);
            chk($sformatf("vec%0d_mode", i), int'(active_mode), int'(v.mode));
        end
        @(negedge clk);
        chk("directed_fc", int'(frame_count), m_fc);

        // Mid-frame mode change is ignored until the next sof.
        for (int i = 0; i < 8; i++)
            src_q.push_back(mk(20*i + 5, 255 - 10*i, 3*i, i == 0, i == 7, (i < 5) ? 0 : 2));
        run_stream(0, 0);
        chk("midframe_mode", int'(active_mode), 0);
        fc_a = m_fc;
        chk("midframe_fc", int'(frame_count), fc_a);
        for (int i = 0; i < 4; i++)
            src_q.push_back(mk(40*i, 10 + i, 200, i == 0, i == 3, 2));
        run_stream(0, 0);
        chk("newframe_mode", int'(active_mode), 2);
        chk("newframe_fc", int'(frame_count), (fc_a + 1) % 65536);

        // Random backpressure (30% low) and bubbles with random per-beat config.
        for (int i = 0; i < 1000; i++) begin
            bt.r = 8'($urandom_range(255)); bt.g = 8'($urandom_range(255));
            bt.b = 8'($urandom_range(255));
            bt.sof = (i % 100 == 0); bt.eol = (i % 10 == 9);
            bt.mode = 3'($urandom_range(7)); bt.gain = 8'($urandom_range(255));
            bt.thresh = 8'($urandom_range(255)); bt.lev = 3'($urandom_range(7));
            src_q.push_back(bt);
        end
        run_stream(30, 20);
        chk("random_fc", int'(frame_count), m_fc);
        chk("random_mode", int'(active_mode), m_mode);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(mk(i + 1, i + 2, i + 3, i == 0, 1'b0, 2));
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_fc", int'(frame_count), 0);
        chk("rst2_mode", int'(active_mode), 0);
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) lat++;
            @(negedge clk);
        end
        chk("rst2_no_stale", lat, 0);
        // Two beats under default shadow (passthrough), then a new inverted frame.
        src_q.push_back(mk(11, 22, 33, 1'b0, 1'b0, 3));
        src_q.push_back(mk(44, 55, 66, 1'b0, 1'b1, 3));
        for (int i = 0; i < 5; i++)
            src_q.push_back(mk(50*i, 7*i, 255 - i, i == 0, i == 4, 2));
        run_stream(0, 0);
        chk("rst2_after_fc", int'(frame_count), 1);
        chk("rst2_after_mode", int'(active_mode), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
